// File: rtl/decode_pipe_stage.sv
// Y86-64 decode stage: D pipeline register, 15-entry register file written from W,
// register-ID decode and forwarded valA/valB for the E register.
module decode_pipe_stage #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = 4'hF,
  parameter logic [3:0] RSP    = 4'h4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        f_stat,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [DATA_W-1:0] f_valC,
  input  logic [DATA_W-1:0] f_valP,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  output logic [3:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [DATA_W-1:0] D_valC,
  output logic [DATA_W-1:0] D_valP,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        d_dstE,
  output logic [3:0]        d_dstM,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB
);

  localparam logic [3:0] STAT_AOK  = 4'b1000;
  localparam logic [3:0] I_NOP     = 4'h1;
  localparam logic [3:0] I_RRMOVQ  = 4'h2;
  localparam logic [3:0] I_IRMOVQ  = 4'h3;
  localparam logic [3:0] I_RMMOVQ  = 4'h4;
  localparam logic [3:0] I_MRMOVQ  = 4'h5;
  localparam logic [3:0] I_OPQ     = 4'h6;
  localparam logic [3:0] I_JXX     = 4'h7;
  localparam logic [3:0] I_CALL    = 4'h8;
  localparam logic [3:0] I_RET     = 4'h9;
  localparam logic [3:0] I_PUSHQ   = 4'hA;
  localparam logic [3:0] I_POPQ    = 4'hB;

  logic [3:0]        r_d_stat;
  logic [3:0]        r_d_icode;
  logic [3:0]        r_d_ifun;
  logic [3:0]        r_d_ra;
  logic [3:0]        r_d_rb;
  logic [DATA_W-1:0] r_d_valc;
  logic [DATA_W-1:0] r_d_valp;

  logic [DATA_W-1:0] r_rf [0:14];

  logic [3:0]        w_src_a;
  logic [3:0]        w_src_b;
  logic [3:0]        w_dst_e;
  logic [3:0]        w_dst_m;
  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic [DATA_W-1:0] w_val_a;
  logic [DATA_W-1:0] w_val_b;

  // Stall dominates bubble; reset dominates both.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || (!D_stall && D_bubble)) begin
      r_d_stat  <= STAT_AOK;
      r_d_icode <= I_NOP;
      r_d_ifun  <= 4'h0;
      r_d_ra    <= RNONE;
      r_d_rb    <= RNONE;
      r_d_valc  <= '0;
      r_d_valp  <= '0;
    end else if (!D_stall) begin
      r_d_stat  <= f_stat;
      r_d_icode <= f_icode;
      r_d_ifun  <= f_ifun;
      r_d_ra    <= f_rA;
      r_d_rb    <= f_rB;
      r_d_valc  <= f_valC;
      r_d_valp  <= f_valP;
    end
  end

  // The later M-port assignment overrides the E-port one when both target the same ID.
  // NOTE: the register file is reset because the architecture defines all registers as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (W_dstE != RNONE) begin
        r_rf[W_dstE] <= W_valE;
      end
      if (W_dstM != RNONE) begin
        r_rf[W_dstM] <= W_valM;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_src_a = RNONE;
    w_src_b = RNONE;
    w_dst_e = RNONE;
    w_dst_m = RNONE;
    case (r_d_icode)
      I_RRMOVQ: begin
        w_src_a = r_d_ra;
        w_dst_e = r_d_rb;
      end
      I_IRMOVQ: begin
        w_dst_e = r_d_rb;
      end
      I_RMMOVQ: begin
        w_src_a = r_d_ra;
        w_src_b = r_d_rb;
      end
      I_MRMOVQ: begin
        w_src_b = r_d_rb;
        w_dst_m = r_d_ra;
      end
      I_OPQ: begin
        w_src_a = r_d_ra;
        w_src_b = r_d_rb;
        w_dst_e = r_d_rb;
      end
      I_CALL: begin
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      I_RET: begin
        w_src_a = RSP;
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      I_PUSHQ: begin
        w_src_a = r_d_ra;
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      I_POPQ: begin
        w_src_a = RSP;
        w_src_b = RSP;
        w_dst_e = RSP;
        w_dst_m = r_d_ra;
      end
      default: begin
        w_src_a = RNONE;
      end
    endcase
  end

  always_comb begin
    w_rf_a = '0;
    w_rf_b = '0;
    if (w_src_a != RNONE) begin
      w_rf_a = r_rf[w_src_a];
    end
    if (w_src_b != RNONE) begin
      w_rf_b = r_rf[w_src_b];
    end
  end

  // Youngest producer wins; a source whose dst is RNONE can never match a real register.
  always_comb begin
    w_val_a = w_rf_a;
    if (r_d_icode == I_JXX || r_d_icode == I_CALL) begin
      w_val_a = r_d_valp;
    end else if (w_src_a == RNONE) begin
      w_val_a = '0;
    end else if (e_dstE != RNONE && w_src_a == e_dstE) begin
      w_val_a = e_valE;
    end else if (M_dstM != RNONE && w_src_a == M_dstM) begin
      w_val_a = m_valM;
    end else if (M_dstE != RNONE && w_src_a == M_dstE) begin
      w_val_a = M_valE;
    end else if (W_dstM != RNONE && w_src_a == W_dstM) begin
      w_val_a = W_valM;
    end else if (W_dstE != RNONE && w_src_a == W_dstE) begin
      w_val_a = W_valE;
    end
  end

  always_comb begin
    w_val_b = w_rf_b;
    if (w_src_b == RNONE) begin
      w_val_b = '0;
    end else if (e_dstE != RNONE && w_src_b == e_dstE) begin
      w_val_b = e_valE;
    end else if (M_dstM != RNONE && w_src_b == M_dstM) begin
      w_val_b = m_valM;
    end else if (M_dstE != RNONE && w_src_b == M_dstE) begin
      w_val_b = M_valE;
    end else if (W_dstM != RNONE && w_src_b == W_dstM) begin
      w_val_b = W_valM;
    end else if (W_dstE != RNONE && w_src_b == W_dstE) begin
      w_val_b = W_valE;
    end
  end

  assign D_stat  = r_d_stat;
  assign D_icode = r_d_icode;
  assign D_ifun  = r_d_ifun;
  assign D_rA    = r_d_ra;
  assign D_rB    = r_d_rb;
  assign D_valC  = r_d_valc;
  assign D_valP  = r_d_valp;
  assign d_srcA  = w_src_a;
  assign d_srcB  = w_src_b;
  assign d_dstE  = w_dst_e;
  assign d_dstM  = w_dst_m;
  assign d_valA  = w_val_a;
  assign d_valB  = w_val_b;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: D register control, decode, register file and forwarding.
module tb_decode_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  f_stat, f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        D_stall, D_bubble;
  logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;

  int n_total = 0;
  int n_bad   = 0;

  decode_pipe_stage dut (
    .clk(clk), .rst(rst),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .D_stall(D_stall), .D_bubble(D_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .M_dstE(M_dstE), .M_valE(M_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_valE(W_valE),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valA(d_valA), .d_valB(d_valB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp);
    f_stat  = 4'b1000;
    f_icode = icode;
    f_ifun  = 4'h0;
    f_rA    = ra;
    f_rB    = rb;
    f_valC  = valc;
    f_valP  = valp;
  endtask

  task automatic fwd_idle();
    e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
    e_valE = '0;   m_valM = '0;   M_valE = '0;   W_valM = '0;   W_valE = '0;
  endtask

  initial begin
    rst = 1'b1;
    D_stall = 1'b0;
    D_bubble = 1'b0;
    fetch(4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    fwd_idle();

    step();
    check("rst_stat",  D_stat, 64'h8);
    check("rst_icode", D_icode, 64'h1);
    check("rst_rA",    D_rA, 64'hF);
    check("rst_srcA",  d_srcA, 64'hF);
    check("rst_srcB",  d_srcB, 64'hF);
    check("rst_dstE",  d_dstE, 64'hF);
    check("rst_dstM",  d_dstM, 64'hF);
    check("rst_valA",  d_valA, 64'h0);
    check("rst_valB",  d_valB, 64'h0);
    rst = 1'b0;

    // irmovq $0x10, %rdx
    fetch(4'h3, 4'hF, 4'h2, 64'h10, 64'hA);
    step();
    check("irm_icode", D_icode, 64'h3);
    check("irm_valC",  D_valC, 64'h10);
    check("irm_dstE",  d_dstE, 64'h2);
    check("irm_srcA",  d_srcA, 64'hF);
    check("irm_valA",  d_valA, 64'h0);

    // OPq %rbx,%rbx: W forwarding in the write cycle, then the RF after the edge
    fetch(4'h6, 4'h3, 4'h3, 64'h0, 64'h2);
    step();
    check("op_valA_pre", d_valA, 64'h0);
    check("op_dstE", d_dstE, 64'h3);
    W_dstE = 4'h3; W_valE = 64'hAB;
    #1;
    check("op_wfwd_A", d_valA, 64'hAB);
    check("op_wfwd_B", d_valB, 64'hAB);
    step();
    fwd_idle();
    #1;
    check("op_rf_A", d_valA, 64'hAB);
    check("op_rf_B", d_valB, 64'hAB);

    // forwarding priority on register 5
    fetch(4'h6, 4'h5, 4'h5, 64'h0, 64'h4);
    step();
    e_dstE = 4'h5; e_valE = 64'h1;
    M_dstE = 4'h5; M_valE = 64'h2;
    W_dstE = 4'h5; W_valE = 64'h3;
    #1;
    check("pri_e_A", d_valA, 64'h1);
    check("pri_e_B", d_valB, 64'h1);
    e_dstE = 4'hF;
    #1;
    check("pri_M_A", d_valA, 64'h2);
    M_dstM = 4'h5; m_valM = 64'h4;
    #1;
    check("pri_Mm_A", d_valA, 64'h4);
    M_dstM = 4'hF; M_dstE = 4'hF;
    #1;
    check("pri_W_A", d_valA, 64'h3);
    W_dstM = 4'h5; W_valM = 64'h5;
    #1;
    check("pri_Wm_B", d_valB, 64'h5);
    fwd_idle();

    // both write ports target register 7: M port wins
    fetch(4'h6, 4'h7, 4'h7, 64'h0, 64'h6);
    W_dstE = 4'h7; W_valE = 64'h11;
    W_dstM = 4'h7; W_valM = 64'h22;
    step();
    fwd_idle();
    #1;
    check("coll_A", d_valA, 64'h22);
    check("coll_B", d_valB, 64'h22);

    // mrmovq decode
    fetch(4'h5, 4'h3, 4'h6, 64'h8, 64'h10);
    step();
    check("mrm_srcA", d_srcA, 64'hF);
    check("mrm_srcB", d_srcB, 64'h6);
    check("mrm_dstE", d_dstE, 64'hF);
    check("mrm_dstM", d_dstM, 64'h3);

    // popq %rbx decode
    fetch(4'hB, 4'h3, 4'hF, 64'h0, 64'h12);
    step();
    check("pop_srcA", d_srcA, 64'h4);
    check("pop_srcB", d_srcB, 64'h4);
    check("pop_dstE", d_dstE, 64'h4);
    check("pop_dstM", d_dstM, 64'h3);

    // call: valA is valP, srcB/dstE are %rsp, valB still forwards
    fetch(4'h8, 4'hF, 4'hF, 64'h100, 64'h40);
    step();
    e_dstE = 4'h4; e_valE = 64'h99;
    M_dstM = 4'hF; W_dstE = 4'hF;
    #1;
    check("call_valA", d_valA, 64'h40);
    check("call_srcB", d_srcB, 64'h4);
    check("call_dstE", d_dstE, 64'h4);
    check("call_valB", d_valB, 64'h99);
    fwd_idle();

    // stall beats bubble for three edges
    fetch(4'h2, 4'h1, 4'h2, 64'h0, 64'h50);
    D_stall = 1'b1; D_bubble = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_icode", D_icode, 64'h8);
    end
    check("stall_valP", D_valP, 64'h40);
    check("stall_valC", D_valC, 64'h100);

    D_stall = 1'b0;
    step();
    check("bub_icode", D_icode, 64'h1);
    check("bub_stat",  D_stat, 64'h8);
    check("bub_valP",  D_valP, 64'h0);
    check("bub_rA",    D_rA, 64'hF);

    D_bubble = 1'b0;
    step();
    check("rr_icode", D_icode, 64'h2);
    check("rr_srcA",  d_srcA, 64'h1);
    check("rr_dstE",  d_dstE, 64'h2);
    check("rr_srcB",  d_srcB, 64'hF);

    // reset during stall loads the bubble and clears the register file
    D_stall = 1'b1; rst = 1'b1;
    step();
    check("rststall_icode", D_icode, 64'h1);
    check("rststall_valP",  D_valP, 64'h0);
    check("rststall_srcA",  d_srcA, 64'hF);
    rst = 1'b0; D_stall = 1'b0;
    fetch(4'h6, 4'h7, 4'h3, 64'h0, 64'h60);
    step();
    check("rfclr_A", d_valA, 64'h0);
    check("rfclr_B", d_valB, 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Decode stage of the Y86-64 five-stage pipeline. It sits directly downstream of fetch and latches the fetch outputs into the D pipeline register, with stall and bubble control. It holds the 15-entry register file, which is written from the W stage. It also generates the source and destination register IDs and produces forwarded valA/valB for the E pipeline register.

## Interface
Parameters:
- DATA_W, 64, register and data width
- RNONE, 4'hF, "no register" ID
- RSP, 4'h4, stack-pointer register ID

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- f_stat  in  4  fetch status {AOK, INS, ADR, HLT}; AOK = 4'b1000
- f_icode, f_ifun, f_rA, f_rB  in  4 each  fetched instruction fields
- f_valC, f_valP  in  64 each  constant word and next-PC
- D_stall  in  1  hold D register
- D_bubble  in  1  load nop into D register
- e_dstE  in  4;  e_valE  in  64  execute-stage result
- M_dstM  in  4;  m_valM  in  64  memory read result
- M_dstE  in  4;  M_valE  in  64  memory-stage ALU result
- W_dstM  in  4;  W_valM  in  64  writeback memory value (also the RF write port M)
- W_dstE  in  4;  W_valE  in  64  writeback ALU value (also the RF write port E)
- D_stat  out  4;  D_icode, D_ifun, D_rA, D_rB  out  4 each;  D_valC, D_valP  out  64 each  registered D fields
- d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  decoded register IDs (combinational from D)
- d_valA, d_valB  out  64 each  forwarded operands (combinational)

## Operation
- D register update, in order of priority:
  - rst: D loads the bubble value.
  - else D_stall=1: hold current value. Stall wins when D_bubble is also 1.
  - else D_bubble=1: load the bubble value.
  - else: load the f_* inputs.
- Bubble value: stat=4'b1000, icode=1 (nop), ifun=0, rA=rB=F, valC=valP=0.
- d_srcA:
  - D_rA for icode 2, 4, 6, A.
  - RSP for icode 9, B.
  - else F.
- d_srcB:
  - D_rB for icode 4, 5, 6.
  - RSP for icode 8, 9, A, B.
  - else F.
- d_dstE:
  - D_rB for icode 2, 3, 6. Conditional-move cancellation happens in execute, not here.
  - RSP for icode 8, 9, A, B.
  - else F.
- d_dstM: D_rA for icode 5, B; else F.
- Register file: 15 x 64, IDs 0-14, all cleared to 0 on rst.
  - On each rising edge, writes W_valE to reg[W_dstE], then W_valM to reg[W_dstM].
  - When both IDs are equal, the W_valM write wins.
  - ID F is never written.
- d_valA selection, first match wins:
  1. D_icode is 7 (jXX) or 8 (call): D_valP.
  2. d_srcA == F: 0.
  3. d_srcA == e_dstE: e_valE.
  4. d_srcA == M_dstM: m_valM.
  5. d_srcA == M_dstE: M_valE.
  6. d_srcA == W_dstM: W_valM.
  7. d_srcA == W_dstE: W_valE.
  8. else reg[d_srcA].
- d_valB: same chain as d_valA using d_srcB, without the valP rule.
- A forwarding source whose dst ID is F never matches.

## Timing
- D_* outputs reflect the f_* inputs one cycle after a rising edge with neither stall nor bubble.
- d_* outputs are combinational from D_* and the forward inputs; there is no added latency.
- An RF write at edge N is visible via reg[] from edge N onward. In the same cycle before edge N, the W forwarding rules already supply the value.
- Reset is synchronous. A rising edge with rst=1 gives:
  - D = bubble value.
  - d_srcA = d_srcB = d_dstE = d_dstM = F.
  - d_valA = d_valB = 0.
  - All RF entries = 0.
- rst mid-stall: reset overrides the stall.
- D_stall held for N cycles: D is unchanged for all N cycles.

## Test plan
- Reset, then fetch irmovq (icode 3, rB=2, valC=0x10) -> after 1 edge: D_icode=3, d_dstE=2, d_srcA=F, d_valA=0.
- W_dstE=3, W_valE=0xAB for one edge, then OPq (icode 6) with rA=3, rB=3 -> d_valA=d_valB=0xAB from the RF. Also check W forwarding in the write cycle itself.
- Forwarding priority: e_dstE=M_dstE=W_dstE=5 with values 1, 2, 3 and srcA=5 -> d_valA=1. Drop e_dstE to F -> 2; also drop M_dstE to F -> 3.
- Ports collide: W_dstE=W_dstM=7 with W_valE=0x11 and W_valM=0x22 on one edge -> reg[7]=0x22.
- call (icode 8) with f_valP=0x40 -> d_valA=0x40, d_srcB=4, d_dstE=4, regardless of any forward match.
- Stall and bubble: D_stall=1 with D_bubble=1 for 3 edges -> D unchanged. Then D_bubble=1 alone -> D_icode=1, D_stat=4'b1000. Then rst asserted during D_stall -> bubble value loaded.
